// File: rtl/dmem_access_unit.sv
// Data-memory access unit: turns CPU load/store burst requests into
// single-word accesses on the data memory port, one word at a time.
module dmem_access_unit #(
  parameter int DEPTH = 256,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_store,
  input  logic [31:0]      req_addr,
  input  logic [LEN_W-1:0] req_len,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [31:0]      wr_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [31:0]      rd_data,
  output logic             done,
  output logic             err,
  output logic [31:0]      mem_addr,
  output logic             mem_mode,
  output logic             mem_write_en,
  output logic [31:0]      mem_write_data,
  input  logic [31:0]      mem_rdata
);

  typedef enum logic [2:0] {IDLE, LOAD, RESP, STORE, DONE} state_t;

  state_t           state, state_nx;
  logic [31:0]      base_q;
  logic [LEN_W-1:0] len_q, cnt_q;
  logic             err_q;

  // Range check is done 33 bits wide so a base near 2^32 cannot wrap into range.
  logic [32:0] end_addr;
  logic        bad_req;
  logic        last;

  assign end_addr = {1'b0, req_addr} + 33'(req_len);
  assign bad_req  = (req_len == '0) || (end_addr > 33'(DEPTH));
  assign last     = (cnt_q == len_q - LEN_W'(1));
  assign mem_addr = base_q + 32'(cnt_q);

  // State register plus burst bookkeeping and the registered load response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      base_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (req_valid) begin
          base_q <= req_addr;
          len_q  <= req_len;
          cnt_q  <= '0;
          err_q  <= bad_req;
        end
        LOAD: begin
          rd_data  <= mem_rdata;
          rd_valid <= 1'b1;
        end
        RESP: if (rd_ready) begin
          rd_valid <= 1'b0;
          if (!last) cnt_q <= cnt_q + LEN_W'(1);
        end
        STORE: if (wr_valid && !last) cnt_q <= cnt_q + LEN_W'(1);
        default: ;
      endcase
    end
  end

  // Next state and memory-port/handshake outputs; defaults keep the memory in read mode.
  always_comb begin
    state_nx       = state;
    req_ready      = 1'b0;
    wr_ready       = 1'b0;
    mem_mode       = 1'b1;
    mem_write_en   = 1'b0;
    mem_write_data = '0;
    done           = 1'b0;
    err            = 1'b0;
    case (state)
      IDLE: begin
        req_ready = !rst;
        if (req_valid) begin
          if (bad_req)        state_nx = DONE;
          else if (req_store) state_nx = STORE;
          else                state_nx = LOAD;
        end
      end
      LOAD: state_nx = RESP;
      RESP: if (rd_ready) state_nx = last ? DONE : LOAD;
      STORE: begin
        wr_ready       = 1'b1;
        mem_mode       = 1'b0;
        mem_write_data = wr_data;
        // Write strobe follows wr_valid directly so the word lands on the handshake edge.
        mem_write_en   = wr_valid;
        if (wr_valid && last) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        err      = err_q;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Bench for dmem_access_unit: behavioural data memory, shadow memory model,
// directed scenarios and randomized bursts.
module tb_dmem_access_unit;
  localparam int DEPTH = 256;
  localparam int LEN_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid, req_ready, req_store;
  logic [31:0]      req_addr;
  logic [LEN_W-1:0] req_len;
  logic             wr_valid, wr_ready;
  logic [31:0]      wr_data;
  logic             rd_valid, rd_ready;
  logic [31:0]      rd_data;
  logic             done, err;
  logic [31:0]      mem_addr, mem_write_data, mem_rdata;
  logic             mem_mode, mem_write_en;

  logic [31:0] mem     [0:DEPTH-1];
  logic [31:0] ref_mem [0:DEPTH-1];
  logic [31:0] wq [$];
  int          n_chk = 0, n_pass = 0;
  bit          prev_hold = 1'b0;

  dmem_access_unit #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_addr(req_addr), .req_len(req_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .done(done), .err(err),
    .mem_addr(mem_addr), .mem_mode(mem_mode), .mem_write_en(mem_write_en),
    .mem_write_data(mem_write_data), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural data memory: combinational read, write on the rising edge.
  assign mem_rdata = (mem_addr < DEPTH) ? mem[mem_addr[7:0]] : 32'h0;
  always @(posedge clk)
    if (mem_write_en && mem_addr < DEPTH) mem[mem_addr[7:0]] <= mem_write_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // One burst: issue the request, play the write/read side, check against the shadow memory.
  task automatic do_req(input bit st, input logic [31:0] base, input int len,
                        input int wmode, input int rlow, input bit rrand, input bit hold);
    int cyc, idx, last_hs, waitc;
    bit rej, seen_done, fv;
    rej = (len == 0) || (longint'(base) + longint'(len) > DEPTH);
    req_valid = 1'b1; req_store = st; req_addr = base; req_len = LEN_W'(len);
    waitc = 0;
    @(negedge clk);
    while (!req_ready && waitc < 20) begin
      @(posedge clk); #1; @(negedge clk); waitc++;
    end
    if (waitc >= 20) begin
      chk("accept_timeout", 32'd1, 32'd0);
      req_valid = 1'b0;
      return;
    end
    if (prev_hold) chk("b2b_accept", 32'(waitc), 32'd0);
    prev_hold = hold;
    @(posedge clk); #1;
    // Scramble the request fields: they must be ignored from here on.
    req_valid = hold; req_addr = $urandom; req_len = LEN_W'($urandom); req_store = 1'($urandom);
    cyc = 0; idx = 0; last_hs = -1; seen_done = 0; fv = 0;
    while (!seen_done && cyc < 200) begin
      cyc++;
      wr_valid = st && (wmode == 1 || (wmode == 2 && cyc % 2 == 1) ||
                        (wmode == 0 && $urandom_range(1) == 1));
      wr_data  = (wq.size() > 0) ? wq[0] : $urandom;
      rd_ready = (cyc > rlow + 1) && (!rrand || $urandom_range(1) == 1);
      @(negedge clk);
      if (done) begin
        seen_done = 1;
        chk("err", 32'(err), 32'(rej));
        chk("done_cyc", 32'(cyc), rej ? 32'd1 : 32'(last_hs + 1));
      end else if (st) begin
        chk("st_mode", 32'(mem_mode), 32'd0);
        chk("st_we", 32'(mem_write_en), 32'(wr_valid));
        chk("st_addr", mem_addr, base + 32'(idx));
        chk("st_wr_ready", 32'(wr_ready), 32'd1);
        chk("st_rd_valid", 32'(rd_valid), 32'd0);
        if (wr_valid) begin
          ref_mem[base + 32'(idx)] = wr_data;
          if (wq.size() > 0) void'(wq.pop_front());
          idx++; last_hs = cyc;
        end
      end else begin
        chk("ld_we", 32'(mem_write_en), 32'd0);
        chk("ld_mode", 32'(mem_mode), 32'd1);
        chk("ld_wr_ready", 32'(wr_ready), 32'd0);
        if (cyc == last_hs + 1 || cyc == 1) chk("ld_gap", 32'(rd_valid), 32'd0);
        if (rd_valid) begin
          if (!fv) begin fv = 1; chk("first_rv", 32'(cyc), 32'd2); end
          chk("rd_data", rd_data, ref_mem[base + 32'(idx)]);
          chk("rd_addr", mem_addr, base + 32'(idx));
          if (rd_ready) begin idx++; last_hs = cyc; end
        end
      end
      @(posedge clk); #1;
    end
    if (!seen_done) chk("done_timeout", 32'd0, 32'd1);
    chk("words", 32'(idx), rej ? 32'd0 : 32'(len));
    if (st && !rej)
      for (int i = 0; i < len; i++) chk("mem", mem[base + 32'(i)], ref_mem[base + 32'(i)]);
    wr_valid = 1'b0; rd_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w21, w22;
    rst = 1'b1; req_valid = 0; req_store = 0; req_addr = 0; req_len = 0;
    wr_valid = 0; wr_data = 0; rd_ready = 0;
    for (int i = 0; i < DEPTH; i++) begin mem[i] = $urandom; ref_mem[i] = mem[i]; end
    mem[0] = 67; mem[1] = 24; mem[2] = 22; mem[3] = 7; mem[4] = 2;
    for (int i = 0; i < 5; i++) ref_mem[i] = mem[i];

    // Reset state.
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_mode", 32'(mem_mode), 32'd1);
    chk("rst_we", 32'(mem_write_en), 32'd0);
    chk("rst_wdata", mem_write_data, 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed scenarios.
    do_req(0, 0, 3, 1, 0, 0, 0);
    wq = '{32'hDEADBEEF, 32'd5};
    do_req(1, 10, 2, 2, 0, 0, 0);
    do_req(0, 4, 1, 1, 5, 0, 0);
    do_req(0, 254, 3, 1, 0, 0, 0);
    do_req(1, 254, 3, 1, 0, 0, 0);
    do_req(0, 5, 0, 1, 0, 0, 0);
    do_req(0, 253, 3, 1, 0, 1, 0);
    do_req(1, 253, 3, 0, 0, 0, 0);

    // Reset in the middle of a store burst.
    w21 = mem[21]; w22 = mem[22];
    req_valid = 1; req_store = 1; req_addr = 20; req_len = 3;
    @(negedge clk);
    chk("mid_accept", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 0; wr_valid = 1; wr_data = 32'h1111_2222;
    @(negedge clk);
    chk("mid_we1", 32'(mem_write_en), 32'd1);
    @(posedge clk); ref_mem[20] = 32'h1111_2222; #1;
    wr_data = 32'h3333_4444;
    #2 rst = 1'b1;
    #1;
    chk("mid_we_drop", 32'(mem_write_en), 32'd0);
    chk("mid_wr_ready", 32'(wr_ready), 32'd0);
    @(negedge clk);
    chk("mid_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0; wr_valid = 0;
    @(negedge clk);
    chk("mid_req_ready", 32'(req_ready), 32'd1);
    chk("mid_done2", 32'(done), 32'd0);
    chk("mid_mem20", mem[20], 32'h1111_2222);
    chk("mid_mem21", mem[21], w21);
    chk("mid_mem22", mem[22], w22);
    @(posedge clk); #1;

    // Back-to-back loads with req_valid held.
    do_req(0, 0, 3, 1, 0, 0, 1);
    do_req(0, 100, 2, 1, 0, 0, 0);

    // Randomized bursts.
    repeat (40) begin
      logic [31:0] b;
      b = ($urandom_range(1) == 1) ? 32'($urandom_range(0, 255)) : 32'($urandom_range(236, 255));
      do_req(1'($urandom_range(1)), b, $urandom_range(0, 15), 0, $urandom_range(0, 2), 1, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
